pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 4-stage CPU: fetch (F), rf_read (R), execute (E), writeback (W).
- Owns the per-stage valid bits and the destination-register scoreboard for E and W.
- Generates PC enable, R-stage valid/IR enable, stall/flush, and the 2-bit writeback-forward select consumed by the rf_read stage.
- Sits beside the datapath. It takes the raw instruction word (mem_data) and the E-stage branch outcome, and drives only control.

Parameters:
- NREG, 8, number of architectural registers; the destination-register field is clog2(NREG) bits wide.
- CALL_LINK_REG, 7, register written by call.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state on the clk edge
- mem_data  in  16  instruction word arriving at the R stage (sync IMEM output)
- ex_br_taken  in  1  E-stage branch/jump/call resolved taken this cycle
- pc_en  out  1  PC register and IMEM fetch advance
- pc_load_target  out  1  PC loads the branch target instead of PC+2
- r_valid  out  1  drives rf_read valid_in
- e_valid  out  1  E-stage instruction valid
- w_valid  out  1  W-stage instruction valid; gates RF write
- stall  out  1  hold F/R, inject bubble into E
- flush  out  1  kill F/R contents
- detect_reg  out  2  [0]=forward W result to A operand, [1]=forward W result to B operand
- w_dest  out  3  W-stage destination register
- w_we  out  1  W-stage writes RF (already qualified by w_valid)

Behaviour:
- Decode of mem_data (opcode = [3:0], imm flag = [4], rA = [7:5], rB = [10:8]):
  - writes_rA: mv(0), add(1), sub(2), mvhi(6), ld(4).
  - call(12) writes CALL_LINK_REG.
  - reads_A: add, sub, cmp(3), st(5), mvhi; also jr(8), jz(9), jn(10), call(12) when [4]=0.
  - reads_B: mv, add, sub, cmp when [4]=0; ld and st always.
  - All other opcodes write and read nothing.
- Registers: r_valid_q, e_valid_q, w_valid_q, e_dest/e_we, w_dest/w_we.
- Values after reset: all valids 0, dests 0, we 0.
  - pc_en=1 and pc_load_target=0 in the first post-reset cycle, so the fetch of address 0 is issued.
  - All other outputs are 0.
- Combinational:
  - flush = e_valid & ex_br_taken.
  - stall = r_valid & e_valid & e_we & ((reads_A & rA==e_dest) | (reads_B & rB==e_dest)) & ~flush. Flush wins over stall.
  - pc_en = ~stall. pc_load_target = flush.
  - detect_reg[0] = r_valid & w_we & reads_A & (rA==w_dest).
  - detect_reg[1] = r_valid & w_we & reads_B & (rB==w_dest).
- Next state:
  - r_valid: flush→0; stall→hold; else→1.
  - e_valid: r_valid & ~stall & ~flush. e_dest/e_we are loaded from decode when advancing; otherwise e_we=0.
  - w_valid/w_dest/w_we take the E values unconditionally (one-cycle shift). A flushing branch in E still retires to W, so call's link write proceeds.
- Latency:
  - First valid R instruction 1 cycle after reset deasserts.
  - An RAW hazard on E costs exactly 1 stall cycle; the dependent instruction then gets a W forward.
  - A taken branch costs 2 bubbles: the R and F slots.
- Boundary cases:
  - No forward from E (no E→R path); hazard vs W is handled only by forwarding.
  - Destination R0 is not special.
  - A dependency on an instruction that was already flushed causes no stall.
  - Reset asserted mid-stall or mid-flush clears everything next edge; no partial state survives.

Optional Feature:
- PIPE_HAZARD_CTRL_PERF_EN.
- When defined, two 16-bit saturating counters are added:
  - stall_cnt: increments each cycle stall=1.
  - flush_cnt: increments each cycle flush=1.
- Both are exposed as outputs stall_cnt[15:0] and flush_cnt[15:0], and both clear on reset.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release with nop stream (opcode 15) → cycle0 pc_en=1, r_valid=0. Cycle1 r_valid=1, cycle2 e_valid=1, cycle3 w_valid=1; stall/flush stay 0.
- add r1,r2 then add r3,r1 (B reads r1) → 1 stall cycle: pc_en=0, next e_valid=0. Following cycle detect_reg=2'b10 with w_dest=1.
- ld r4,[r5] then st r4,[r6] (A reads r4) → stall 1 cycle, then detect_reg[0]=1 with w_dest=4, w_we=1.
- jz taken (ex_br_taken=1 while e_valid=1) → flush=1, pc_load_target=1, r_valid=0 next cycle and e_valid=0 the cycle after. The jz itself reaches W.
- Simultaneous hazard + taken branch in E → stall=0, flush=1. call with link write reaches W with w_dest=7, w_we=1.
- PERF_EN build: 3 stalls + 2 flushes → stall_cnt=3, flush_cnt=2. Force 70000 stall cycles → stall_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central control for the F/R/E/W pipeline.
// Tracks per-stage valid bits and the E/W destination scoreboard, detects
// read-after-write hazards against E (stall) and against W (forward select),
// and turns a taken E-stage branch into a flush of the F and R slots.
// Optional build macro: PIPE_HAZARD_CTRL_PERF_EN adds saturating
// stall_cnt / flush_cnt outputs.
module pipe_hazard_ctrl #(
   parameter int NREG          = 8,
   parameter int CALL_LINK_REG = 7
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [15:0]              mem_data,
   input  logic                     ex_br_taken,
   output logic                     pc_en,
   output logic                     pc_load_target,
   output logic                     r_valid,
   output logic                     e_valid,
   output logic                     w_valid,
   output logic                     stall,
   output logic                     flush,
   output logic [1:0]               detect_reg,
   output logic [$clog2(NREG)-1:0]  w_dest,
   output logic                     w_we
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   ,
   output logic [15:0]              stall_cnt,
   output logic [15:0]              flush_cnt
`endif
);

   localparam int RW = $clog2(NREG);

   localparam logic [3:0] OP_MV   = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_CMP  = 4'd3;
   localparam logic [3:0] OP_LD   = 4'd4;
   localparam logic [3:0] OP_ST   = 4'd5;
   localparam logic [3:0] OP_MVHI = 4'd6;
   localparam logic [3:0] OP_JR   = 4'd8;
   localparam logic [3:0] OP_JZ   = 4'd9;
   localparam logic [3:0] OP_JN   = 4'd10;
   localparam logic [3:0] OP_CALL = 4'd12;

   logic [3:0]    opcode;
   logic          imm;
   logic [RW-1:0] ra;
   logic [RW-1:0] rb;
   logic          writes;
   logic          reads_a;
   logic          reads_b;
   logic [RW-1:0] dest;
   logic          advance;

   logic          r_valid_q;
   logic          e_valid_q;
   logic          w_valid_q;
   logic [RW-1:0] e_dest_q;
   logic          e_we_q;
   logic [RW-1:0] w_dest_q;
   logic          w_we_q;

   assign opcode = mem_data[3:0];
   assign imm    = mem_data[4];
   assign ra     = RW'(mem_data[7:5]);
   assign rb     = RW'(mem_data[10:8]);

   // Decode which registers the R-stage word reads and which one it writes
   always_comb begin
      writes  = 1'b0;
      reads_a = 1'b0;
      reads_b = 1'b0;
      dest    = ra;
      case (opcode)
         OP_MV: begin
            writes  = 1'b1;
            reads_b = ~imm;
         end
         OP_ADD, OP_SUB: begin
            writes  = 1'b1;
            reads_a = 1'b1;
            reads_b = ~imm;
         end
         OP_CMP: begin
            reads_a = 1'b1;
            reads_b = ~imm;
         end
         OP_LD: begin
            writes  = 1'b1;
            reads_b = 1'b1;
         end
         OP_ST: begin
            reads_a = 1'b1;
            reads_b = 1'b1;
         end
         OP_MVHI: begin
            writes  = 1'b1;
            reads_a = 1'b1;
         end
         OP_JR, OP_JZ, OP_JN: begin
            reads_a = ~imm;
         end
         OP_CALL: begin
            writes  = 1'b1;
            reads_a = ~imm;
            dest    = RW'(CALL_LINK_REG);
         end
         default: begin
         end
      endcase
   end

   // Hazard, flush and forwarding decisions; a taken branch overrides a stall
   always_comb begin
      flush = e_valid_q & ex_br_taken;
      stall = r_valid_q & e_valid_q & e_we_q &
              ((reads_a & (ra == e_dest_q)) | (reads_b & (rb == e_dest_q))) & ~flush;
      pc_en          = ~stall;
      pc_load_target = flush;
      detect_reg[0]  = r_valid_q & w_we & reads_a & (ra == w_dest_q);
      detect_reg[1]  = r_valid_q & w_we & reads_b & (rb == w_dest_q);
      advance        = r_valid_q & ~stall & ~flush;
   end

   assign r_valid = r_valid_q;
   assign e_valid = e_valid_q;
   assign w_valid = w_valid_q;
   assign w_dest  = w_dest_q;
   assign w_we    = w_valid_q & w_we_q;

   // Stage valids and destination scoreboard; W simply shifts E every cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid_q <= 1'b0;
         e_valid_q <= 1'b0;
         w_valid_q <= 1'b0;
         e_dest_q  <= '0;
         e_we_q    <= 1'b0;
         w_dest_q  <= '0;
         w_we_q    <= 1'b0;
      end else begin
         if (flush)
            r_valid_q <= 1'b0;
         else if (!stall)
            r_valid_q <= 1'b1;
         e_valid_q <= advance;
         if (advance) begin
            e_dest_q <= dest;
            e_we_q   <= writes;
         end else begin
            e_we_q   <= 1'b0;
         end
         w_valid_q <= e_valid_q;
         w_dest_q  <= e_dest_q;
         w_we_q    <= e_we_q;
      end
   end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   // Saturating event counters for stall and flush cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
         if (flush && (flush_cnt != 16'hFFFF))
            flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif

endmodule
